// File: rtl/e_digit_streamer.sv
// Streams a latched fixed-point e_calculator result as ASCII "D.ddd..." over valid/ready.
// Each fractional digit is the carry out of a word-serial multiply-by-10 of the fraction.
module e_digit_streamer #(
    parameter int WORDS = 32,
    parameter int NDIG  = 100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] result [0:2*WORDS-1],
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  dbg_state
);

    localparam int NW = 2 * WORDS;
    localparam int IW = $clog2(NW);
    localparam int KW = $clog2(NDIG + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INT, S_DOT, S_MUL, S_EMIT, S_FIN
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_buf [0:NW-1];
    logic [IW-1:0] r_idx;
    logic [3:0]    r_carry;
    logic [KW-1:0] r_k;
    logic          r_gap;
    logic          r_err;

    logic [19:0]   w_prod;
    logic [15:0]   w_int;
    logic          w_mul_last;
    logic          w_k_last;

    // Valid/ready: a byte transfers on a cycle where out_valid && out_ready; while
    // out_valid && !out_ready, out_data and out_valid hold; out_valid drops the cycle
    // after every transfer, so bytes are never back-to-back.
    assign w_int      = r_buf[NW-1];
    assign w_prod     = {4'd0, r_buf[r_idx]} * 20'd10 + {16'd0, r_carry};
    assign w_mul_last = (r_idx == IW'(NW - 2));
    assign w_k_last   = ((r_k + KW'(1)) == KW'(NDIG));
    assign err        = r_err;
    assign dbg_state  = r_state;

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_INT;
            end
            S_INT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = (w_int > 16'd9) ? 8'h23 : (8'h30 + w_int[7:0]);
                if (out_ready) w_next = S_DOT;
            end
            S_DOT: begin
                // r_gap inserts the idle cycle between the integer byte and the point
                busy      = 1'b1;
                out_valid = !r_gap;
                out_data  = 8'h2E;
                if (!r_gap && out_ready) w_next = (NDIG == 0) ? S_FIN : S_MUL;
            end
            S_MUL: begin
                busy = 1'b1;
                if (w_mul_last) w_next = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = 8'h30 + {4'd0, r_carry};
                if (out_ready) w_next = w_k_last ? S_FIN : S_MUL;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NW; i++) r_buf[i] <= 16'd0;
            r_idx   <= '0;
            r_carry <= 4'd0;
            r_k     <= '0;
            r_gap   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < NW; i++) r_buf[i] <= result[i];
                    r_err <= (result[NW-1] > 16'd9);
                    r_k   <= '0;
                    r_gap <= 1'b0;
                end
                S_INT: begin
                    if (out_ready) r_gap <= 1'b1;
                end
                S_DOT: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (out_ready) begin
                        r_idx   <= '0;
                        r_carry <= 4'd0;
                    end
                end
                S_MUL: begin
                    // the carry out of the most significant fraction word is the digit
                    r_buf[r_idx] <= w_prod[15:0];
                    r_carry      <= w_prod[19:16];
                    r_idx        <= r_idx + IW'(1);
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_k     <= r_k + KW'(1);
                        r_idx   <= '0;
                        r_carry <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
